// File: rtl/uart_sys_pkg.sv
// Shared types for the UART loopback datapath: frame status and echo controller states.
package uart_sys_pkg;

   typedef enum logic {
      FRAME_OK  = 1'b0,
      FRAME_ERR = 1'b1
   } frame_err_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DE_SETUP  = 3'd1,
      ST_LOAD      = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_DE_HOLD   = 3'd4
   } echo_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; the head word is always visible on rd_data_o.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage is not reset; a simultaneous read and write on a full FIFO reuses the head slot safely.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign level_o   = LW'(wr_ptr_q - rd_ptr_q);
   assign full_o    = (level_o == LW'(DEPTH));
   assign empty_o   = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/uart_echo_fifo_ctrl.sv
// RS485 echo controller: buffers uart_rx words and replays them to uart_tx with driver-enable guard times.
//   state        | meaning
//   ST_IDLE      | driver off, waiting for a buffered word
//   ST_DE_SETUP  | driver on, guard time before the first word
//   ST_LOAD      | waiting for the transmitter to go idle, then start a word
//   ST_WAIT_DONE | word in flight, waiting for tx_done
//   ST_DE_HOLD   | driver held on for the guard time after the last word
module uart_echo_fifo_ctrl
   import uart_sys_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 16,
   parameter int GUARD_CYCLES = 434,
   parameter int LED_HOLD     = 5_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           rx_data,
   input  logic                       rx_valid,
   input  logic                       rx_error,
   input  logic                       tx_busy,
   input  logic                       tx_done,
   output logic                       tx_start,
   output logic [WIDTH-1:0]           tx_data,
   output logic                       en_rs485,
   output logic                       led_rx,
   output logic                       led_err,
   output logic                       overflow,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic [15:0]                err_count
);
   localparam int GW = $clog2(GUARD_CYCLES+1);
   localparam int HW = $clog2(LED_HOLD+1);

   echo_state_e      state_q, state_d;
   logic [GW-1:0]    guard_q, guard_d;
   logic [HW-1:0]    led_rx_cnt_q, led_rx_cnt_d;
   logic [HW-1:0]    led_err_cnt_q, led_err_cnt_d;
   logic             tx_start_q, en_q, led_rx_q, led_err_q, ovf_q;
   logic [WIDTH-1:0] tx_data_q;
   logic [15:0]      err_q;

   logic [WIDTH-1:0] fifo_head;
   logic             fifo_full, fifo_empty;
   logic             fire, push_req, push_ok, drop, err_evt;
   frame_err_e       rx_kind;

   assign rx_kind  = frame_err_e'(rx_error);
   assign push_req = rx_valid && (rx_kind == FRAME_OK);
   assign err_evt  = rx_valid && (rx_kind == FRAME_ERR);
   assign push_ok  = push_req && (!fifo_full || fire);
   assign drop     = push_req && fifo_full && !fire;

   uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (push_ok),
      .wr_data_i (rx_data),
      .rd_en_i   (fire),
      .rd_data_o (fifo_head),
      .level_o   (fifo_level),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   // The last DE_SETUP cycle also evaluates the LOAD condition so the first start lands right at guard expiry.
   always_comb begin
      state_d = state_q;
      guard_d = guard_q;
      fire    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_DE_SETUP;
               guard_d = GW'(GUARD_CYCLES - 1);
            end
         end
         ST_DE_SETUP: begin
            if (guard_q != '0) begin
               guard_d = guard_q - GW'(1);
            end else if (!tx_busy && !fifo_empty) begin
               fire    = 1'b1;
               state_d = ST_WAIT_DONE;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!tx_busy && !fifo_empty) begin
               fire    = 1'b1;
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done) begin
               if (!fifo_empty) begin
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_DE_HOLD;
                  guard_d = GW'(GUARD_CYCLES);
               end
            end
         end
         ST_DE_HOLD: begin
            if (!fifo_empty)          state_d = ST_LOAD;
            else if (guard_q != '0)   guard_d = guard_q - GW'(1);
            else                      state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      led_rx_cnt_d  = led_rx_cnt_q;
      led_err_cnt_d = led_err_cnt_q;
      if (push_ok)                    led_rx_cnt_d = HW'(LED_HOLD);
      else if (led_rx_cnt_q != '0)    led_rx_cnt_d = led_rx_cnt_q - HW'(1);
      if (err_evt || drop)            led_err_cnt_d = HW'(LED_HOLD);
      else if (led_err_cnt_q != '0)   led_err_cnt_d = led_err_cnt_q - HW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         guard_q       <= '0;
         led_rx_cnt_q  <= '0;
         led_err_cnt_q <= '0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         en_q          <= 1'b0;
         led_rx_q      <= 1'b0;
         led_err_q     <= 1'b0;
         ovf_q         <= 1'b0;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         guard_q       <= guard_d;
         led_rx_cnt_q  <= led_rx_cnt_d;
         led_err_cnt_q <= led_err_cnt_d;
         tx_start_q    <= fire;
         if (fire) tx_data_q <= fifo_head;
         en_q          <= (state_d != ST_IDLE);
         led_rx_q      <= (led_rx_cnt_d != '0);
         led_err_q     <= (led_err_cnt_d != '0);
         if (drop)    ovf_q <= 1'b1;
         if (err_evt) err_q <= sat_inc16(err_q);
      end
   end

   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign en_rs485  = en_q;
   assign led_rx    = led_rx_q;
   assign led_err   = led_err_q;
   assign overflow  = ovf_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_uart_echo_fifo_ctrl.sv
// Bench for uart_echo_fifo_ctrl: table vectors, timing sequences and a queue-based reference under random traffic.
module tb_uart_echo_fifo_ctrl;
   localparam int DEPTH  = 4;
   localparam int GUARD  = 4;
   localparam int HOLD   = 8;
   localparam int TX_LAT = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid, rx_error, tx_busy, tx_done;
   logic       tx_start, en_rs485, led_rx, led_err, overflow;
   logic [7:0] tx_data;
   logic [2:0] fifo_level;
   logic [15:0] err_count;

   uart_echo_fifo_ctrl #(
      .WIDTH(8), .DEPTH(DEPTH), .GUARD_CYCLES(GUARD), .LED_HOLD(HOLD)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
      .en_rs485(en_rs485), .led_rx(led_rx), .led_err(led_err), .overflow(overflow),
      .fifo_level(fifo_level), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic        e;
      logic [7:0]  d;
      logic [2:0]  lvl;
      logic        ovf;
      logic [15:0] errc;
      logic        en;
      logic        lrx;
      logic        lerr;
   } vec_t;

   vec_t tbl [18];

   int   n_chk = 0, n_pass = 0, cyc = 0, tx_cnt = 0, last_done = -100;
   logic hold_busy = 1'b0;
   logic [7:0] mq [$];
   logic m_ovf = 1'b0;
   int   m_err = 0;

   int   en_rises, starts, first_start, first_rise, first_fall, lrx_hi;
   logic prev_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // One clock: drive inputs, let the DUT clock them, then update the reference and compare.
   task automatic step(input logic v, input logic e, input logic [7:0] d);
      logic full_before;
      rx_valid = v; rx_error = e; rx_data = d;
      if (tx_cnt > 0) begin
         tx_cnt--;
         tx_done = (tx_cnt == 0);
      end else begin
         tx_done = 1'b0;
      end
      tx_busy = hold_busy | (tx_cnt != 0);
      if (tx_done) last_done = cyc;
      full_before = (mq.size() == DEPTH);
      @(posedge clk); #1; cyc++;
      if (tx_start) begin
         chk("pop_nonempty", mq.size() != 0, 1);
         if (mq.size() != 0) chk("tx_data", tx_data, mq.pop_front());
         chk("en_at_start", en_rs485, 1);
         tx_cnt = TX_LAT + 1;
      end
      if (v && !e) begin
         if (!full_before || tx_start) mq.push_back(d);
         else m_ovf = 1'b1;
      end
      if (v && e && m_err < 65535) m_err++;
      chk("fifo_level", fifo_level, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("err_count", err_count, m_err);
   endtask

   task automatic clr_stats();
      en_rises = 0; starts = 0; first_start = -1; first_rise = -1; first_fall = -1; lrx_hi = 0;
      prev_en = en_rs485;
   endtask

   task automatic stepm(input logic v, input logic e, input logic [7:0] d);
      step(v, e, d);
      if (en_rs485 && !prev_en) begin
         en_rises++;
         if (first_rise < 0) first_rise = cyc;
      end
      if (!en_rs485 && prev_en && first_fall < 0) first_fall = cyc;
      prev_en = en_rs485;
      if (tx_start) begin
         starts++;
         if (first_start < 0) first_start = cyc;
      end
      if (led_rx) lrx_hi++;
   endtask

   task automatic do_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; rx_data = '0;
      tx_busy = 1'b0; tx_done = 1'b0; hold_busy = 1'b0; tx_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      mq.delete(); m_ovf = 1'b0; m_err = 0; cyc = 0; last_done = -100;
      chk("rst_en", en_rs485, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_err", err_count, 0);
      chk("rst_leds", {led_rx, led_err}, 0);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int d1;
      //            v     e     d      lvl   ovf   err     en    lrx   lerr
      tbl[0]  = '{1'b1, 1'b1, 8'hEE, 3'd0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 1'b1, 8'hEE, 3'd0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 8'hEE, 3'd0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 8'h01, 3'd1, 1'b0, 16'd3, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 8'h02, 3'd2, 1'b0, 16'd3, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 8'h03, 3'd3, 1'b0, 16'd3, 1'b1, 1'b1, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 8'h04, 3'd4, 1'b0, 16'd3, 1'b1, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 8'h05, 3'd4, 1'b1, 16'd3, 1'b1, 1'b1, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 8'h06, 3'd4, 1'b1, 16'd3, 1'b1, 1'b1, 1'b1};
      for (int i = 10; i < 18; i++)
         tbl[i] = '{1'b0, 1'b0, 8'h00, 3'd4, 1'b1, 16'd3, 1'b1, (i <= 14), (i <= 16)};

      // Single word: guard before start, guard after done, LED stretch.
      do_reset();
      clr_stats();
      stepm(1'b1, 1'b0, 8'hA5);
      chk("t1_en_cyc1", en_rs485, 0);
      repeat (40) stepm(1'b0, 1'b0, 8'h00);
      chk("t1_en_rise", first_rise, 2);
      chk("t1_start", first_start, 2 + GUARD);
      chk("t1_en_fall", first_fall, 2 + GUARD + TX_LAT + 2 + GUARD);
      chk("t1_led_rx_len", lrx_hi, HOLD);
      chk("t1_starts", starts, 1);
      chk("t1_tx_data_held", tx_data, 8'hA5);

      // Back-to-back words share one driver window.
      do_reset();
      clr_stats();
      stepm(1'b1, 1'b0, 8'h11);
      stepm(1'b1, 1'b0, 8'h22);
      stepm(1'b1, 1'b0, 8'h33);
      for (int i = 0; i < 80; i++) begin
         stepm(1'b0, 1'b0, 8'h00);
         if (tx_start && starts > 1) chk("t2_gap", cyc - last_done, 2);
      end
      chk("t2_starts", starts, 3);
      chk("t2_en_windows", en_rises, 1);
      chk("t2_en_final", en_rs485, 0);

      // Frame errors and overflow while the transmitter is held busy.
      do_reset();
      hold_busy = 1'b1;
      for (int i = 0; i < 18; i++) begin
         step(tbl[i].v, tbl[i].e, tbl[i].d);
         chk("tbl_level", fifo_level, tbl[i].lvl);
         chk("tbl_ovf", overflow, tbl[i].ovf);
         chk("tbl_err", err_count, tbl[i].errc);
         chk("tbl_en", en_rs485, tbl[i].en);
         chk("tbl_led_rx", led_rx, tbl[i].lrx);
         chk("tbl_led_err", led_err, tbl[i].lerr);
      end
      hold_busy = 1'b0;
      clr_stats();
      repeat (120) stepm(1'b0, 1'b0, 8'h00);
      chk("t3_echoed", starts, 4);
      chk("t3_last_word", tx_data, 8'h04);

      // Arrival in the second DE_HOLD cycle reloads without dropping the driver.
      do_reset();
      stepm(1'b1, 1'b0, 8'h3C);
      for (int i = 0; i < 40 && last_done < 0; i++) stepm(1'b0, 1'b0, 8'h00);
      chk("t4_done_seen", last_done >= 0, 1);
      d1 = last_done;
      clr_stats();
      stepm(1'b0, 1'b0, 8'h00);
      stepm(1'b1, 1'b0, 8'h4D);
      repeat (30) stepm(1'b0, 1'b0, 8'h00);
      chk("t4_start", first_start, d1 + 5);
      chk("t4_no_reenable", en_rises, 0);
      chk("t4_fall", first_fall, d1 + 5 + TX_LAT + 2 + GUARD);

      // Full FIFO with a push coinciding with the pop.
      do_reset();
      hold_busy = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h61 + 8'(i));
      repeat (10) step(1'b0, 1'b0, 8'h00);
      hold_busy = 1'b0;
      step(1'b1, 1'b0, 8'h65);
      chk("t4b_start", tx_start, 1);
      chk("t4b_level", fifo_level, 4);
      chk("t4b_no_ovf", overflow, 0);
      chk("t4b_data", tx_data, 8'h61);
      clr_stats();
      repeat (80) stepm(1'b0, 1'b0, 8'h00);
      chk("t4b_drained", starts, 4);
      chk("t4b_last", tx_data, 8'h65);

      // Asynchronous reset while a word is in flight.
      do_reset();
      step(1'b1, 1'b1, 8'h00);
      step(1'b1, 1'b0, 8'h71);
      step(1'b1, 1'b0, 8'h72);
      for (int i = 0; i < 30 && !tx_start; i++) step(1'b0, 1'b0, 8'h00);
      chk("t5_start_seen", tx_start, 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_en", en_rs485, 0);
      chk("t5_tx_start", tx_start, 0);
      chk("t5_level", fifo_level, 0);
      chk("t5_err", err_count, 0);
      do_reset();

      // Random traffic against the queue reference.
      clr_stats();
      for (int i = 0; i < 1500; i++) begin
         logic v, e;
         if ($urandom_range(49) == 0) hold_busy = !hold_busy;
         v = ($urandom_range(3) == 0);
         e = v && ($urandom_range(7) == 0);
         stepm(v, e, 8'($urandom));
      end
      hold_busy = 1'b0;
      repeat (200) stepm(1'b0, 1'b0, 8'h00);
      chk("rnd_drained", mq.size(), 0);
      chk("rnd_en_final", en_rs485, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
